// File: rtl/datamem_arb_pkg.sv
// Shared types for the datamem arbiter: FSM states, port id, latched request payload.
// Round-robin arbitration is enabled with DATAMEM_ARB_ROUND_ROBIN_EN (see datamem_arb_grant).
package datamem_arb_pkg;

    localparam int unsigned LAT_CNT_W  = 4;
    localparam int unsigned PKG_ADDR_W = 64;
    localparam int unsigned PKG_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef logic port_id_t;

    // Sized for the widest supported configuration; narrower ports are zero-extended.
    typedef struct packed {
        logic                  write;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] wdata;
        logic [3:0]            xfer;
    } mem_req_t;

endpackage

// File: rtl/datamem_arb_grant.sv
// Grant selection for the two requesters; only grants while the sequencer is idle.
// DATAMEM_ARB_ROUND_ROBIN_EN: ties go to the port not granted last; otherwise port 0 wins ties.
module datamem_arb_grant
    import datamem_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_idle,
`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
    input  port_id_t   i_ptr,
    output port_id_t   o_ptr_next,
`endif
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        if (i_idle) begin
            unique case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
                // i_ptr holds the last granted port
                2'b11:   o_grant = i_ptr ? 2'b01 : 2'b10;
`else
                2'b11:   o_grant = 2'b01;
`endif
                default: o_grant = '0;
            endcase
        end
    end

`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        o_ptr_next = i_ptr;
        if (o_grant[1])
            o_ptr_next = 1'b1;
        else if (o_grant[0])
            o_ptr_next = 1'b0;
    end
`endif

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter/sequencer in front of datamem: one access at a time, held MEM_LAT cycles.
// Define DATAMEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: port 0 priority).
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [3:0]        req0_xfer,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [3:0]        req1_xfer,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_xfer_size,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

    arb_state_e            r_state;
    arb_state_e            w_state_next;
    logic [LAT_CNT_W-1:0]  r_cnt;
    port_id_t              r_port;
    mem_req_t              r_req;
    logic [PKG_DATA_W-1:0] r_rdata;

    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_idle;
    logic                  w_last;
    mem_req_t              w_req_sel;

    // Reset blocks acceptance so a held valid is not taken on the reset edge.
    assign w_idle   = (r_state == IDLE) && !reset;
    assign w_accept = |w_grant;
    assign w_last   = (r_cnt == '0);

`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
    port_id_t r_ptr;
    port_id_t w_ptr_next;

    datamem_arb_grant u_grant (
        .i_valid    ({req1_valid, req0_valid}),
        .i_idle     (w_idle),
        .i_ptr      (r_ptr),
        .o_ptr_next (w_ptr_next),
        .o_grant    (w_grant)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= 1'b1;
        else
            r_ptr <= w_ptr_next;
    end
`else
    datamem_arb_grant u_grant (
        .i_valid (Fill_valid()),
        .i_idle  (w_idle),
        .o_grant (w_grant)
    );

    function automatic logic [1:0] Fill_valid();
        return {req1_valid, req0_valid};
    endfunction
`endif

    always_comb begin
        w_req_sel = '0;
        if (w_grant[1]) begin
            w_req_sel.write = req1_write;
            w_req_sel.addr  = PKG_ADDR_W'(req1_addr);
            w_req_sel.wdata = PKG_DATA_W'(req1_wdata);
            w_req_sel.xfer  = req1_xfer;
        end else begin
            w_req_sel.write = req0_write;
            w_req_sel.addr  = PKG_ADDR_W'(req0_addr);
            w_req_sel.wdata = PKG_DATA_W'(req0_wdata);
            w_req_sel.xfer  = req0_xfer;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_port  <= 1'b0;
            r_req   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req   <= w_req_sel;
                        r_port  <= w_grant[1];
                        r_cnt   <= LAT_LOAD;
                        r_rdata <= '0;
                    end
                end
                ACCESS: begin
                    if (w_last) begin
                        if (!r_req.write)
                            r_rdata <= PKG_DATA_W'(mem_read_data);
                    end else begin
                        r_cnt <= r_cnt - LAT_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = ACCESS;
            ACCESS:  if (w_last)   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready       = w_grant[0];
        req1_ready       = w_grant[1];
        req0_done        = 1'b0;
        req1_done        = 1'b0;
        req0_rdata       = '0;
        req1_rdata       = '0;
        mem_addr         = '0;
        mem_write_data   = '0;
        mem_xfer_size    = '0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        busy             = (r_state != IDLE);
        unique case (r_state)
            ACCESS: begin
                mem_addr         = r_req.addr[ADDR_W-1:0];
                mem_write_data   = r_req.wdata[DATA_W-1:0];
                mem_xfer_size    = r_req.xfer;
                mem_read_enable  = !r_req.write;
                // Store strobe only on the last held cycle: exactly one write per access
                mem_write_enable = r_req.write && w_last;
            end
            RESP: begin
                if (r_port) begin
                    req1_done  = 1'b1;
                    req1_rdata = r_rdata[DATA_W-1:0];
                end else begin
                    req0_done  = 1'b1;
                    req0_rdata = r_rdata[DATA_W-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter: three instances (MEM_LAT 2, 1, 3) over one memory model.
// Honours DATAMEM_ARB_ROUND_ROBIN_EN for the expected tie-break order.
module tb_datamem_arbiter;

    localparam int NI = 3;
    localparam int LATS [NI] = '{2, 1, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [NI];
    logic        v    [NI][2];
    logic        wr   [NI][2];
    logic [63:0] ad   [NI][2];
    logic [63:0] wd   [NI][2];
    logic [3:0]  xf   [NI][2];
    logic        rdy  [NI][2];
    logic        dn   [NI][2];
    logic [63:0] rdt  [NI][2];
    logic [63:0] m_addr [NI];
    logic [63:0] m_wd   [NI];
    logic [63:0] m_rd   [NI];
    logic [3:0]  m_xf   [NI];
    logic        m_re   [NI];
    logic        m_we   [NI];
    logic        bsy    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        datamem_arbiter #(
            .ADDR_W  (64),
            .DATA_W  (64),
            .MEM_LAT (LATS[g])
        ) u_dut (
            .clk              (clk),
            .reset            (rst[g]),
            .req0_valid       (v[g][0]),
            .req0_write       (wr[g][0]),
            .req0_addr        (ad[g][0]),
            .req0_wdata       (wd[g][0]),
            .req0_xfer        (xf[g][0]),
            .req0_ready       (rdy[g][0]),
            .req0_done        (dn[g][0]),
            .req0_rdata       (rdt[g][0]),
            .req1_valid       (v[g][1]),
            .req1_write       (wr[g][1]),
            .req1_addr        (ad[g][1]),
            .req1_wdata       (wd[g][1]),
            .req1_xfer        (xf[g][1]),
            .req1_ready       (rdy[g][1]),
            .req1_done        (dn[g][1]),
            .req1_rdata       (rdt[g][1]),
            .mem_addr         (m_addr[g]),
            .mem_write_data   (m_wd[g]),
            .mem_xfer_size    (m_xf[g]),
            .mem_read_enable  (m_re[g]),
            .mem_write_enable (m_we[g]),
            .mem_read_data    (m_rd[g]),
            .busy             (bsy[g])
        );
    end

    // Memory: 256 x 64-bit words, initialised to a recognisable pattern.
    function automatic logic [63:0] pat(input int unsigned idx);
        return 64'hA5A5_0000_0000_0000 | 64'(idx);
    endfunction

    logic [63:0] mem [256];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else begin
            for (int g = 0; g < NI; g++)
                if (m_we[g]) mem[m_addr[g][10:3]] <= m_wd[g];
        end
    end

    always_comb begin
        for (int g = 0; g < NI; g++)
            m_rd[g] = m_re[g] ? mem[m_addr[g][10:3]] : '0;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        $display("FAIL %s: event not seen within bound (expected it to occur)", name);
    endtask

    // Scoreboard for instance 0: expected rdata per port, pushed when a request is driven.
    logic [63:0] sbq0 [$];
    logic [63:0] sbq1 [$];
    int unsigned grants [$];

    task automatic push_exp(input int unsigned p, input logic [63:0] e);
        if (p == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rdy[0][0]) grants.push_back(0);
        if (rdy[0][1]) grants.push_back(1);
        if (dn[0][0] && dn[0][1]) fail_evt("done_exclusive");
        if (dn[0][0]) begin
            if (sbq0.size() == 0) fail_evt("sb_expected_req0");
            else chk("sb_rdata0", rdt[0][0], sbq0.pop_front());
        end
        if (dn[0][1]) begin
            if (sbq1.size() == 0) fail_evt("sb_expected_req1");
            else chk("sb_rdata1", rdt[0][1], sbq1.pop_front());
        end
    end

    typedef struct {
        int unsigned port;
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  xfer;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    // One isolated access on instance 0 (MEM_LAT 2) with cycle-by-cycle checks.
    task automatic run_vec(input vec_t vv);
        int unsigned p;
        int unsigned q;
        p = vv.port;
        q = 1 - p;
        @(posedge clk); #1;
        v[0][p]  = 1'b1;
        wr[0][p] = vv.write;
        ad[0][p] = vv.addr;
        wd[0][p] = vv.wdata;
        xf[0][p] = vv.xfer;
        push_exp(p, vv.exp_rdata);
        @(negedge clk);
        chk("vec_ready", rdy[0][p], 1);
        chk("vec_ready_other", rdy[0][q], 0);
        chk("vec_busy_idle", bsy[0], 0);
        @(posedge clk); #1;
        v[0][p] = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("acc_busy", bsy[0], 1);
            chk("acc_addr", m_addr[0], vv.addr);
            chk("acc_xfer", m_xf[0], vv.xfer);
            chk("acc_wdata", m_wd[0], vv.wdata);
            chk("acc_read_en", m_re[0], !vv.write);
            chk("acc_write_en", m_we[0], vv.write && (k == 2));
            chk("acc_no_done", dn[0][p], 0);
        end
        @(negedge clk);
        chk("resp_done", dn[0][p], 1);
        chk("resp_busy", bsy[0], 1);
        chk("resp_mem_we", m_we[0], 0);
        @(negedge clk);
        chk("idle_busy", bsy[0], 0);
        chk("idle_done", dn[0][p], 0);
        chk("idle_mem_addr", m_addr[0], 0);
    endtask

    // Three back-to-back loads from one port of instance 0, obeying the requester rules.
    task automatic requester(input int unsigned p);
        int unsigned idx;
        logic        got;
        for (int n = 0; n < 3; n++) begin
            idx = 16 + p * 4 + n;
            @(posedge clk); #1;
            v[0][p]  = 1'b1;
            wr[0][p] = 1'b0;
            ad[0][p] = 64'(idx * 8);
            wd[0][p] = '0;
            xf[0][p] = 4'd8;
            push_exp(p, pat(idx));
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                got = rdy[0][p];
            end
            if (!got) fail_evt("tie_ready");
            @(posedge clk); #1;
            v[0][p] = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                got = dn[0][p];
            end
            if (!got) fail_evt("tie_done");
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned exp_order [6];
        logic        got;
        int          cyc;

        mem_init = 1'b1;
        for (int g = 0; g < NI; g++) begin
            rst[g] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                v[g][p] = 1'b0; wr[g][p] = 1'b0; ad[g][p] = '0; wd[g][p] = '0; xf[g][p] = '0;
            end
        end
        v[0][0] = 1'b1;

        vecs[0] = '{0, 1'b1, 64'h10,  64'hDEAD_BEEF,            4'd8, 64'h0};
        vecs[1] = '{1, 1'b0, 64'h10,  64'h0,                    4'd8, 64'hDEAD_BEEF};
        vecs[2] = '{1, 1'b1, 64'h18,  64'h0123_4567_89AB_CDEF,  4'd4, 64'h0};
        vecs[3] = '{0, 1'b0, 64'h18,  64'h0,                    4'd4, 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{0, 1'b0, 64'h20,  64'h0,                    4'd2, 64'hA5A5_0000_0000_0004};
        vecs[5] = '{1, 1'b0, 64'h7F8, 64'h0,                    4'd1, 64'hA5A5_0000_0000_00FF};

        // Reset state, with a valid held on instance 0 port 0 to confirm no grant under reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk("rst_ready0", rdy[g][0], 0);
            chk("rst_ready1", rdy[g][1], 0);
            chk("rst_done0", dn[g][0], 0);
            chk("rst_rdata0", rdt[g][0], 0);
            chk("rst_busy", bsy[g], 0);
            chk("rst_mem_re", m_re[g], 0);
            chk("rst_mem_we", m_we[g], 0);
            chk("rst_mem_addr", m_addr[g], 0);
        end
        v[0][0] = 1'b0;
        @(posedge clk); #1;
        mem_init = 1'b0;
        for (int g = 0; g < NI; g++) rst[g] = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Tie-break order with both ports requesting.
        grants.delete();
        fork
            requester(0);
            requester(1);
        join
`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 1, 1, 1};
`endif
        chk("tie_grant_count", 64'(grants.size()), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk("tie_grant_order", 64'(grants[i]), 64'(exp_order[i]));

        // Port 1 valid while port 0 is in flight: held off until IDLE.
        @(posedge clk); #1;
        v[0][0] = 1'b1; wr[0][0] = 1'b0; ad[0][0] = 64'h30; wd[0][0] = '0; xf[0][0] = 4'd8;
        push_exp(0, pat(6));
        @(negedge clk);
        chk("blk_ready0", rdy[0][0], 1);
        @(posedge clk); #1;
        v[0][0] = 1'b0;
        v[0][1] = 1'b1; wr[0][1] = 1'b0; ad[0][1] = 64'h38; wd[0][1] = '0; xf[0][1] = 4'd8;
        push_exp(1, pat(7));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("blk_ready1_held", rdy[0][1], 0);
            chk("blk_busy", bsy[0], 1);
        end
        @(negedge clk);
        chk("blk_ready1_idle", rdy[0][1], 1);
        chk("blk_busy_idle", bsy[0], 0);
        @(posedge clk); #1;
        v[0][1] = 1'b0;
        repeat (5) @(posedge clk);

        // MEM_LAT = 1 (instance 1): done at t+2, next accept at t+3.
        @(posedge clk); #1;
        v[1][0] = 1'b1; wr[1][0] = 1'b0; ad[1][0] = 64'h28; xf[1][0] = 4'd8;
        @(negedge clk);
        chk("l1_ready", rdy[1][0], 1);
        @(posedge clk); #1;
        v[1][0] = 1'b0;
        @(negedge clk);
        chk("l1_read_en", m_re[1], 1);
        chk("l1_addr", m_addr[1], 64'h28);
        chk("l1_no_done", dn[1][0], 0);
        @(posedge clk); #1;
        v[1][1] = 1'b1; wr[1][1] = 1'b0; ad[1][1] = 64'h40; xf[1][1] = 4'd8;
        @(negedge clk);
        chk("l1_done", dn[1][0], 1);
        chk("l1_rdata", rdt[1][0], pat(5));
        chk("l1_resp_no_ready", rdy[1][1], 0);
        chk("l1_resp_read_en", m_re[1], 0);
        @(negedge clk);
        chk("l1_next_ready", rdy[1][1], 1);
        chk("l1_done_pulse", dn[1][0], 0);
        @(posedge clk); #1;
        v[1][1] = 1'b0;
        @(negedge clk);
        chk("l1_read_en2", m_re[1], 1);
        @(negedge clk);
        chk("l1_done2", dn[1][1], 1);
        chk("l1_rdata2", rdt[1][1], pat(8));

        // MEM_LAT = 3 (instance 2): reset in the first ACCESS cycle of a store.
        @(posedge clk); #1;
        v[2][0] = 1'b1; wr[2][0] = 1'b1; ad[2][0] = 64'h50; wd[2][0] = 64'h55; xf[2][0] = 4'd8;
        @(negedge clk);
        chk("l3_ready", rdy[2][0], 1);
        @(posedge clk); #1;
        v[2][0] = 1'b0;
        rst[2]  = 1'b1;
        @(negedge clk);
        chk("l3_rst_busy", bsy[2], 1);
        chk("l3_rst_we", m_we[2], 0);
        @(posedge clk); #1;
        rst[2] = 1'b0;
        @(negedge clk);
        chk("l3_after_busy", bsy[2], 0);
        chk("l3_after_we", m_we[2], 0);
        chk("l3_after_re", m_re[2], 0);
        chk("l3_after_addr", m_addr[2], 0);
        chk("l3_after_wdata", m_wd[2], 0);
        chk("l3_after_done", dn[2][0], 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("l3_quiet_we", m_we[2], 0);
            chk("l3_quiet_done", dn[2][0], 0);
        end

        // Memory untouched by the abandoned store; LAT 3 load completes 4 cycles after accept.
        @(posedge clk); #1;
        v[2][0] = 1'b1; wr[2][0] = 1'b0; ad[2][0] = 64'h50; wd[2][0] = '0;
        @(negedge clk);
        chk("l3_reload_ready", rdy[2][0], 1);
        @(posedge clk); #1;
        v[2][0] = 1'b0;
        got = 1'b0;
        cyc = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            cyc++;
            if (dn[2][0]) begin
                got = 1'b1;
                chk("l3_reload_rdata", rdt[2][0], pat(10));
                chk("l3_done_cycle", 64'(cyc), 4);
            end
        end
        if (!got) fail_evt("l3_reload_done");

        repeat (4) @(posedge clk);
        chk("sb_drained0", 64'(sbq0.size()), 0);
        chk("sb_drained1", 64'(sbq1.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
